// File: rtl/huffman_tree_builder.sv
// Builds a canonical Huffman decode tree in external RAM from per-symbol code lengths.
// Optional error checking is enabled by defining HUFFMAN_TREE_BUILDER_ERRCHK_EN.
module huffman_tree_builder #(
    parameter int NUMCODES = 288,
    parameter int OUTWIDTH = 10,
    localparam int AW = $clog2(2*NUMCODES-1)
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                istart,
    input  logic                ilen_en,
    input  logic [3:0]          ilen,
    input  logic                ilen_last,
    output logic                olen_rdy,
    output logic                obusy,
    output logic                odone,
    output logic                oerr,
    output logic                twen,
    output logic [AW-1:0]       twaddr,
    output logic [OUTWIDTH-1:0] twdata,
    output logic [AW-1:0]       traddr,
    input  logic [OUTWIDTH-1:0] trdata
);
    localparam int NW = AW - 1;
    localparam logic [OUTWIDTH-1:0] UNSET    = '1;
    localparam logic [OUTWIDTH-1:0] NC_OFS   = OUTWIDTH'(NUMCODES);
    localparam logic [AW-1:0]       CLR_LAST = AW'(2*NUMCODES-1);
    localparam logic [AW-1:0]       CLR_NUM  = AW'(NUMCODES);
    localparam logic [NW-1:0]       SYM_LAST = NW'(NUMCODES-1);
    localparam logic [NW-1:0]       NODE_MAX = NW'(NUMCODES-2);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, NEXTC, BUILD_RD, BUILD_CHK, DONE} state_t;
    state_t state, state_next;

    logic [AW-1:0] clr_cnt, rd_addr;
    logic [NW-1:0] sym, node, nodefilled;
    logic [3:0]    nb, bitpos;
    logic          walking;
    logic [15:0]   code, cur_code;
    logic [15:0]   bl_count [16];
    logic [15:0]   next_code [16];
    logic [3:0]    len_mem [NUMCODES];

    logic [3:0]    len_cur;
    logic [15:0]   nc_sel, code_next;
    logic [AW-1:0] walk_addr;
    logic [NW-1:0] filled_inc;
    logic          err_set;

    always_comb begin
        len_cur    = len_mem[sym];
        nc_sel     = next_code[len_cur];
        code_next  = (code + ((nb == 4'd1) ? 16'd0 : bl_count[nb - 4'd1])) << 1;
        filled_inc = nodefilled + NW'(1);
        // A new symbol starts its walk at the root with the code's MSB.
        if (walking) walk_addr = {node, cur_code[bitpos]};
        else         walk_addr = {{NW{1'b0}}, nc_sel[len_cur - 4'd1]};
    end

    always_comb begin
        state_next = state;
        olen_rdy   = 1'b0;
        odone      = 1'b0;
        twen       = 1'b0;
        twaddr     = '0;
        twdata     = '0;
        traddr     = '0;
        err_set    = 1'b0;
        case (state)
            IDLE:  if (istart) state_next = CLEAR;
            CLEAR: begin
                twen   = 1'b1;
                twaddr = clr_cnt;
                twdata = UNSET;
                if (clr_cnt == CLR_LAST) state_next = LOAD;
            end
            LOAD: begin
                olen_rdy = 1'b1;
                if (ilen_en && (ilen_last || sym == SYM_LAST)) state_next = NEXTC;
            end
            NEXTC: if (nb == 4'd15) state_next = BUILD_RD;
            BUILD_RD: begin
                if (walking || len_cur != 4'd0) begin
                    traddr     = walk_addr;
                    state_next = BUILD_CHK;
                end else if (sym == SYM_LAST) begin
                    state_next = DONE;
                end
            end
            BUILD_CHK: begin
                if (bitpos == 4'd0) begin
`ifdef HUFFMAN_TREE_BUILDER_ERRCHK_EN
                    err_set = (trdata != UNSET);
`endif
                    if (!err_set) begin
                        twen   = 1'b1;
                        twaddr = rd_addr;
                        twdata = OUTWIDTH'(sym);
                    end
                    state_next = (err_set || sym == SYM_LAST) ? DONE : BUILD_RD;
                end else begin
                    if (trdata == UNSET) begin
`ifdef HUFFMAN_TREE_BUILDER_ERRCHK_EN
                        err_set = (filled_inc > NODE_MAX);
`endif
                        if (!err_set) begin
                            twen   = 1'b1;
                            twaddr = rd_addr;
                            twdata = OUTWIDTH'(filled_inc) + NC_OFS;
                        end
                    end
                    state_next = err_set ? DONE : BUILD_RD;
                end
            end
            DONE: begin
                odone      = 1'b1;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
        // A restart wins over everything, so an aborted build never reports done.
        if (istart && state != IDLE) begin
            state_next = CLEAR;
            odone      = 1'b0;
            olen_rdy   = 1'b0;
        end
    end

    assign obusy = (state != IDLE);

    // NOTE: all sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!rstn) state <= IDLE;
        else       state <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rstn || istart) begin
            clr_cnt    <= '0;
            rd_addr    <= '0;
            sym        <= '0;
            node       <= '0;
            nodefilled <= '0;
            nb         <= 4'd1;
            bitpos     <= '0;
            walking    <= 1'b0;
            code       <= '0;
            cur_code   <= '0;
            for (int i = 0; i < 16; i++) bl_count[i] <= '0;
        end else begin
            case (state)
                CLEAR: begin
                    clr_cnt <= clr_cnt + AW'(1);
                    for (int i = 0; i < 16; i++) bl_count[i] <= '0;
                end
                LOAD: if (ilen_en) begin
                    sym <= (ilen_last || sym == SYM_LAST) ? '0 : sym + NW'(1);
                    if (ilen != 4'd0) bl_count[ilen] <= bl_count[ilen] + 16'd1;
                end
                NEXTC: begin
                    code <= code_next;
                    nb   <= nb + 4'd1;
                end
                BUILD_RD: begin
                    if (walking || len_cur != 4'd0) begin
                        rd_addr <= walk_addr;
                        if (!walking) begin
                            cur_code <= nc_sel;
                            bitpos   <= len_cur - 4'd1;
                            node     <= '0;
                            walking  <= 1'b1;
                        end
                    end else begin
                        sym <= sym + NW'(1);
                    end
                end
                BUILD_CHK: begin
                    if (bitpos == 4'd0) begin
                        walking <= 1'b0;
                        sym     <= sym + NW'(1);
                    end else begin
                        bitpos <= bitpos - 4'd1;
                        if (trdata == UNSET) begin
                            nodefilled <= filled_inc;
                            node       <= filled_inc;
                        end else begin
                            node <= NW'(trdata - NC_OFS);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    // NOTE: the length store and next_code are plain storage with no reset; CLEAR and NEXTC initialise them.
    always_ff @(posedge clk) begin
        if (state == CLEAR && clr_cnt < CLR_NUM) len_mem[clr_cnt[NW-1:0]] <= '0;
        if (state == LOAD && ilen_en) len_mem[sym] <= ilen;
        if (state == NEXTC) next_code[nb] <= code_next;
        if (state == BUILD_RD && !walking && len_cur != 4'd0) next_code[len_cur] <= nc_sel + 16'd1;
    end

`ifdef HUFFMAN_TREE_BUILDER_ERRCHK_EN
    logic err_q;
    always_ff @(posedge clk) begin
        if (!rstn || istart) err_q <= 1'b0;
        else if (err_set)    err_q <= 1'b1;
    end
    assign oerr = err_q;
`else
    assign oerr = 1'b0;
`endif

endmodule

// File: tb/tb_huffman_tree_builder.sv
// Directed testbench for huffman_tree_builder with a behavioural 1-cycle-latency tree RAM.
module tb_huffman_tree_builder;
    localparam int NUMCODES = 288;
    localparam int OUTWIDTH = 10;
    localparam int AW       = 10;
    localparam int TREESZ   = 2*NUMCODES;
    localparam logic [9:0] UNSET = 10'h3ff;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic istart = 1'b0;
    logic ilen_en = 1'b0;
    logic [3:0] ilen = 4'd0;
    logic ilen_last = 1'b0;
    logic olen_rdy, obusy, odone, oerr, twen;
    logic [AW-1:0] twaddr, traddr;
    logic [OUTWIDTH-1:0] twdata;
    logic [OUTWIDTH-1:0] trdata;

    logic [9:0] ram [1024];
    logic [9:0] exp_tree [TREESZ];
    int total = 0;
    int bad = 0;
    int odone_cnt = 0;

    always #5 clk = ~clk;

    huffman_tree_builder #(.NUMCODES(NUMCODES), .OUTWIDTH(OUTWIDTH)) dut (
        .clk(clk), .rstn(rstn), .istart(istart), .ilen_en(ilen_en), .ilen(ilen),
        .ilen_last(ilen_last), .olen_rdy(olen_rdy), .obusy(obusy), .odone(odone),
        .oerr(oerr), .twen(twen), .twaddr(twaddr), .twdata(twdata),
        .traddr(traddr), .trdata(trdata)
    );

    always @(posedge clk) begin
        if (twen === 1'b1) ram[twaddr] <= twdata;
        trdata <= ram[traddr];
    end

    always @(negedge clk) if (odone === 1'b1) odone_cnt++;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_build();
        istart = 1'b1;
        step();
        istart = 1'b0;
    endtask

    task automatic wait_rdy(output int n);
        n = 0;
        while (olen_rdy !== 1'b1 && n < 2000) begin
            step();
            n++;
        end
    endtask

    task automatic feed(input int len, input bit last);
        ilen_en   = 1'b1;
        ilen      = 4'(len);
        ilen_last = last;
        step();
        ilen_en   = 1'b0;
        ilen_last = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n;
        n = 0;
        while (odone !== 1'b1 && n < 3000) begin
            step();
            n++;
        end
        check(tag, 32'(odone), 1);
        repeat (5) step();
    endtask

    task automatic clear_exp();
        for (int i = 0; i < TREESZ; i++) exp_tree[i] = UNSET;
    endtask

    task automatic set_exp_2133();
        clear_exp();
        exp_tree[0] = 10'd1;
        exp_tree[1] = 10'd289;
        exp_tree[2] = 10'd0;
        exp_tree[3] = 10'd290;
        exp_tree[4] = 10'd2;
        exp_tree[5] = 10'd3;
    endtask

    task automatic check_tree(input string tag);
        int errs;
        errs = 0;
        for (int i = 0; i < TREESZ; i++) if (ram[i] !== exp_tree[i]) errs++;
        check(tag, 32'(errs), 0);
    endtask

    task automatic feed_2133();
        feed(2, 1'b0);
        feed(1, 1'b0);
        feed(3, 1'b0);
        feed(3, 1'b1);
    endtask

    initial begin
        int n;
        repeat (3) step();
        check("rst_obusy", 32'(obusy), 0);
        check("rst_odone", 32'(odone), 0);
        check("rst_oerr", 32'(oerr), 0);
        check("rst_olen_rdy", 32'(olen_rdy), 0);
        check("rst_twen", 32'(twen), 0);
        check("rst_twaddr", 32'(twaddr), 0);
        check("rst_twdata", 32'(twdata), 0);
        check("rst_traddr", 32'(traddr), 0);
        rstn = 1'b1;
        step();

        // Lengths 2,1,3,3: reference tree.
        odone_cnt = 0;
        start_build();
        check("a_busy", 32'(obusy), 1);
        wait_rdy(n);
        check("a_clear_cycles", 32'(n), 576);
        feed_2133();
        check("a_rdy_drop", 32'(olen_rdy), 0);
        wait_done("a_done");
        check("a_odone_cnt", 32'(odone_cnt), 1);
        check("a_oerr", 32'(oerr), 0);
        check("a_idle", 32'(obusy), 0);
        check("a_addr0", 32'(ram[0]), 1);
        check("a_addr1", 32'(ram[1]), 289);
        check("a_addr2", 32'(ram[2]), 0);
        check("a_addr3", 32'(ram[3]), 290);
        check("a_addr4", 32'(ram[4]), 2);
        check("a_addr5", 32'(ram[5]), 3);
        set_exp_2133();
        check_tree("a_tree");

        // Single zero length: all-UNSET tree.
        odone_cnt = 0;
        start_build();
        wait_rdy(n);
        feed(0, 1'b1);
        wait_done("b_done");
        check("b_odone_cnt", 32'(odone_cnt), 1);
        check("b_oerr", 32'(oerr), 0);
        clear_exp();
        check_tree("b_tree");

        // Oversubscribed lengths 1,1,1.
        odone_cnt = 0;
        start_build();
        wait_rdy(n);
        feed(1, 1'b0);
        feed(1, 1'b0);
        feed(1, 1'b1);
        wait_done("c_done");
        check("c_odone_cnt", 32'(odone_cnt), 1);
`ifdef HUFFMAN_TREE_BUILDER_ERRCHK_EN
        check("c_oerr", 32'(oerr), 1);
`else
        check("c_oerr", 32'(oerr), 0);
`endif

        // Abort during BUILD, then rebuild with lengths 1,1.
        odone_cnt = 0;
        start_build();
        check("d_oerr_cleared", 32'(oerr), 0);
        wait_rdy(n);
        feed_2133();
        repeat (20) step();
        check("d_busy_in_build", 32'(obusy), 1);
        start_build();
        wait_rdy(n);
        check("d_clear_cycles", 32'(n), 576);
        check("d_no_early_done", 32'(odone_cnt), 0);
        feed(1, 1'b0);
        feed(1, 1'b1);
        wait_done("d_done");
        check("d_odone_cnt", 32'(odone_cnt), 1);
        clear_exp();
        exp_tree[0] = 10'd0;
        exp_tree[1] = 10'd1;
        check_tree("d_tree");

        // Reset pulse during CLEAR, then a normal build.
        odone_cnt = 0;
        start_build();
        repeat (10) step();
        rstn = 1'b0;
        step();
        check("e_obusy", 32'(obusy), 0);
        check("e_twen", 32'(twen), 0);
        check("e_olen_rdy", 32'(olen_rdy), 0);
        rstn = 1'b1;
        step();
        start_build();
        wait_rdy(n);
        feed_2133();
        wait_done("e_done");
        check("e_odone_cnt", 32'(odone_cnt), 1);
        set_exp_2133();
        check_tree("e_tree");

        // ilen_en pulses during CLEAR must be ignored.
        odone_cnt = 0;
        start_build();
        ilen_en = 1'b1;
        ilen    = 4'd1;
        repeat (50) step();
        ilen_en = 1'b0;
        wait_rdy(n);
        feed_2133();
        wait_done("f_done");
        check("f_odone_cnt", 32'(odone_cnt), 1);
        set_exp_2133();
        check_tree("f_tree");

        // All NUMCODES lengths supplied without ilen_last: automatic end of LOAD.
        odone_cnt = 0;
        start_build();
        wait_rdy(n);
        for (int i = 0; i < NUMCODES; i++) feed(0, 1'b0);
        check("g_rdy_drop", 32'(olen_rdy), 0);
        wait_done("g_done");
        check("g_odone_cnt", 32'(odone_cnt), 1);
        clear_exp();
        check_tree("g_tree");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
